// File: rtl/ssd_arb_pkg.sv
// rtl/ssd_arb_pkg.sv - shared encodings and defaults for the seven-segment display arbiter.
// Optional feature macro used by the arbiter: SSD_ARB_PRIORITY_EN.
package ssd_arb_pkg;

  localparam int OWN_W                = 2;
  localparam int DEFAULT_DATA_W       = 32;
  localparam int DEFAULT_DWELL_CYCLES = 100_000_000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_OPEN = 2'd2
  } arb_state_t;

endpackage

// File: rtl/ssd_rr_picker.sv
// rtl/ssd_rr_picker.sv - combinational round-robin winner search upward from a pointer with wrap.
module ssd_rr_picker
  import ssd_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [NUM_REQ-1:0] i_mask,
  input  logic [OWN_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [OWN_W-1:0]   o_idx,
  output logic               o_valid
);

  localparam logic [OWN_W:0] LP_NUM = (OWN_W+1)'(NUM_REQ);

  logic [NUM_REQ-1:0] w_cand;
  logic [OWN_W:0]     w_pos;
  logic [OWN_W-1:0]   w_idx;

  always_comb begin
    w_cand  = i_req & i_mask;
    w_pos   = '0;
    w_idx   = '0;
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_pos = {1'b0, i_ptr} + k[OWN_W:0];
      if (w_pos >= LP_NUM) w_pos = w_pos - LP_NUM;
      w_idx = w_pos[OWN_W-1:0];
      if (!o_valid && w_cand[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        o_idx          = w_idx;
        o_valid        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ssd_display_arbiter.sv
// rtl/ssd_display_arbiter.sv - round-robin owner of the 8-digit display with a minimum dwell time.
// Optional requester-0 override build: SSD_ARB_PRIORITY_EN.
module ssd_display_arbiter
  import ssd_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int DWELL_CYCLES = DEFAULT_DWELL_CYCLES,
  parameter int DATA_W       = DEFAULT_DATA_W
) (
  input  logic                      ssd_arbiter_clk,
  input  logic                      ssd_arbiter_rst_n,
  input  logic [NUM_REQ-1:0]        ssd_arbiter_req,
  input  logic [NUM_REQ*DATA_W-1:0] ssd_arbiter_data,
  output logic [NUM_REQ-1:0]        ssd_arbiter_grant,
  output logic [OWN_W-1:0]          ssd_arbiter_owner,
  output logic [DATA_W-1:0]         ssd_arbiter_value,
  output logic                      ssd_arbiter_busy
);

  localparam int CNT_W = (DWELL_CYCLES > 2) ? $clog2(DWELL_CYCLES) : 1;
  // Ownership lasts exactly DWELL_CYCLES clocks: OPEN is entered as the count reaches its last value.
  localparam logic [CNT_W-1:0] LP_PRE_LAST = CNT_W'(DWELL_CYCLES - 2);
  localparam logic [OWN_W-1:0] LP_LAST_IDX = OWN_W'(NUM_REQ - 1);

  arb_state_t          r_state, w_next_state;
  logic [CNT_W-1:0]    r_count, w_next_count;
  logic [OWN_W-1:0]    r_ptr, w_next_ptr;
  logic [OWN_W-1:0]    r_owner, w_next_owner;
  logic [NUM_REQ-1:0]  r_grant, w_next_grant;
  logic [DATA_W-1:0]   r_value;
  logic                r_busy;

  logic [NUM_REQ-1:0]  w_pick_grant;
  logic [OWN_W-1:0]    w_pick_idx;
  logic                w_pick_valid;
  logic                w_own_req;
  logic [DATA_W-1:0]   w_data [NUM_REQ];
  logic [DATA_W-1:0]   w_sel_data;

  genvar g;
  generate
    for (g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign w_data[g] = ssd_arbiter_data[g*DATA_W +: DATA_W];
    end
  endgenerate

  // Masking the current owner means a pick is always a different requester; in IDLE r_grant is zero.
  ssd_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .i_req   (ssd_arbiter_req),
    .i_mask  (~r_grant),
    .i_ptr   (r_ptr),
    .o_grant (w_pick_grant),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_valid)
  );

  assign w_own_req = |(ssd_arbiter_req & r_grant);

`ifdef SSD_ARB_PRIORITY_EN
  logic r_req0_q;
  logic w_override;

  always_ff @(posedge ssd_arbiter_clk or negedge ssd_arbiter_rst_n) begin
    if (!ssd_arbiter_rst_n) r_req0_q <= 1'b0;
    else                    r_req0_q <= ssd_arbiter_req[0];
  end

  assign w_override = (r_state != ST_IDLE) && (r_owner != '0) &&
                      ssd_arbiter_req[0] && !r_req0_q;
`endif

  always_comb begin
    w_next_state = r_state;
    w_next_count = r_count;
    w_next_ptr   = r_ptr;
    w_next_owner = r_owner;
    w_next_grant = r_grant;

    case (r_state)
      ST_IDLE: begin
        if (w_pick_valid) w_next_state = ST_HOLD;
      end
      ST_HOLD: begin
        if (!w_own_req) begin
          w_next_state = w_pick_valid ? ST_HOLD : ST_IDLE;
        end else if (r_count == LP_PRE_LAST) begin
          w_next_state = ST_OPEN;
          w_next_count = r_count + 1'b1;
        end else begin
          w_next_count = r_count + 1'b1;
        end
      end
      ST_OPEN: begin
        if (w_pick_valid)    w_next_state = ST_HOLD;
        else if (!w_own_req) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase

    // A fresh round-robin grant: from IDLE, on release with others pending, or from OPEN.
    if (w_pick_valid && (r_state == ST_IDLE || r_state == ST_OPEN ||
                         (r_state == ST_HOLD && !w_own_req))) begin
      w_next_count = '0;
      w_next_grant = w_pick_grant;
      w_next_owner = w_pick_idx;
      w_next_ptr   = (w_pick_idx == LP_LAST_IDX) ? '0 : w_pick_idx + 1'b1;
    end

    if (w_next_state == ST_IDLE) begin
      w_next_grant = '0;
      w_next_count = '0;
    end

`ifdef SSD_ARB_PRIORITY_EN
    if (w_override) begin
      w_next_state    = ST_HOLD;
      w_next_count    = '0;
      w_next_grant    = '0;
      w_next_grant[0] = 1'b1;
      w_next_owner    = '0;
      w_next_ptr      = r_ptr;
    end
`endif
  end

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_next_owner == OWN_W'(i)) w_sel_data = w_data[i];
    end
  end

  always_ff @(posedge ssd_arbiter_clk or negedge ssd_arbiter_rst_n) begin
    if (!ssd_arbiter_rst_n) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_ptr   <= '0;
      r_owner <= '0;
      r_grant <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_count <= w_next_count;
      r_ptr   <= w_next_ptr;
      r_owner <= w_next_owner;
      r_grant <= w_next_grant;
      r_busy  <= (w_next_state != ST_IDLE);
    end
  end

  // Value tracks the next-state owner so a new grant and its data land on the same edge.
  always_ff @(posedge ssd_arbiter_clk or negedge ssd_arbiter_rst_n) begin
    if (!ssd_arbiter_rst_n)              r_value <= '0;
    else if (w_next_state != ST_IDLE)    r_value <= w_sel_data;
  end

  assign ssd_arbiter_grant = r_grant;
  assign ssd_arbiter_owner = r_owner;
  assign ssd_arbiter_value = r_value;
  assign ssd_arbiter_busy  = r_busy;

endmodule

// File: tb/tb_ssd_display_arbiter.sv
// tb/tb_ssd_display_arbiter.sv - directed self-checking bench for ssd_display_arbiter, DWELL_CYCLES=10.
module tb_ssd_display_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DWELL   = 10;
  localparam int DATA_W  = 32;

  logic                      clk;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] data;
  logic [NUM_REQ-1:0]        grant;
  logic [1:0]                owner;
  logic [DATA_W-1:0]         value;
  logic                      busy;

  int n_checks;
  int n_errors;

  ssd_display_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .DWELL_CYCLES (DWELL),
    .DATA_W       (DATA_W)
  ) dut (
    .ssd_arbiter_clk   (clk),
    .ssd_arbiter_rst_n (rst_n),
    .ssd_arbiter_req   (req),
    .ssd_arbiter_data  (data),
    .ssd_arbiter_grant (grant),
    .ssd_arbiter_owner (owner),
    .ssd_arbiter_value (value),
    .ssd_arbiter_busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    req      = '0;
    data     = '0;

    step();
    check("rst_grant", 64'(grant), 64'h0);
    check("rst_owner", 64'(owner), 64'h0);
    check("rst_value", 64'(value), 64'h0);
    check("rst_busy",  64'(busy),  64'h0);
    rst_n = 1'b1;
    step();
    check("idle_grant", 64'(grant), 64'h0);

    // First grant from IDLE: requester 2, pointer then 3.
    data[2*DATA_W +: DATA_W] = 32'h1234_5678;
    req = 4'b0100;
    step();
    check("g2_grant", 64'(grant), 64'h4);
    check("g2_owner", 64'(owner), 64'h2);
    check("g2_value", 64'(value), 64'h1234_5678);
    check("g2_busy",  64'(busy),  64'h1);
    req = 4'b0000;
    step();
    check("g2_rel_grant", 64'(grant), 64'h0);
    check("g2_rel_busy",  64'(busy),  64'h0);
    check("g2_rel_value", 64'(value), 64'h1234_5678);

    // Req0 and req2 contend: pointer 3 wraps to 0, each holds exactly DWELL clocks.
    data[0 +: DATA_W] = 32'h0000_00A0;
    req = 4'b0101;
    step();
    check("rr_first_value", 64'(value), 64'hA0);
    for (int i = 0; i < DWELL; i++) begin
      check($sformatf("rr_hold0_%0d", i), 64'(grant), 64'h1);
      if (i < DWELL - 1) step();
    end
    step();
    check("rr_switch2_grant", 64'(grant), 64'h4);
    check("rr_switch2_value", 64'(value), 64'h1234_5678);
    for (int i = 1; i < DWELL; i++) begin
      step();
      check($sformatf("rr_hold2_%0d", i), 64'(grant), 64'h4);
    end
    step();
    check("rr_back0_grant", 64'(grant), 64'h1);
    check("rr_back0_owner", 64'(owner), 64'h0);
    req = 4'b0000;
    step();
    check("rr_idle_busy", 64'(busy), 64'h0);

    // Requester 1 alone stays in OPEN indefinitely; release leaves value untouched.
    data[1*DATA_W +: DATA_W] = 32'h1111_1111;
    req = 4'b0010;
    step();
    check("open1_grant", 64'(grant), 64'h2);
    repeat (3 * DWELL) step();
    check("open1_held_grant", 64'(grant), 64'h2);
    check("open1_held_busy",  64'(busy),  64'h1);
    req = 4'b0000;
    data[1*DATA_W +: DATA_W] = 32'hDEAD_BEEF;
    step();
    check("open1_rel_grant", 64'(grant), 64'h0);
    check("open1_rel_busy",  64'(busy),  64'h0);
    check("open1_rel_value", 64'(value), 64'h1111_1111);

    // Owner 3 releases at count 4 with req1 pending; new dwell restarts from zero.
    data[3*DATA_W +: DATA_W] = 32'h3333_3333;
    req = 4'b1000;
    step();
    check("o3_grant", 64'(grant), 64'h8);
    req = 4'b1010;
    step();
    check("o3_ignore_req1", 64'(grant), 64'h8);
    repeat (3) step();
    req = 4'b0010;
    step();
    check("o3_rel_to1_grant", 64'(grant), 64'h2);
    check("o3_rel_to1_value", 64'(value), 64'hDEAD_BEEF);
    req = 4'b1010;
    for (int i = 1; i < DWELL; i++) begin
      step();
      check($sformatf("o1_restart_%0d", i), 64'(grant), 64'h2);
    end
    step();
    check("o1_to3_grant", 64'(grant), 64'h8);
    req = 4'b0000;
    step();
    check("o3_idle_grant", 64'(grant), 64'h0);

    // Live data update from owner 2 appears one clock later.
    data[2*DATA_W +: DATA_W] = 32'hAAAA_0000;
    req = 4'b0100;
    step();
    check("live_grant", 64'(grant), 64'h4);
    check("live_v0",    64'(value), 64'hAAAA_0000);
    step();
    data[2*DATA_W +: DATA_W] = 32'hAAAA_0001;
    check("live_v0_hold", 64'(value), 64'hAAAA_0000);
    step();
    check("live_v1", 64'(value), 64'hAAAA_0001);

    // Asynchronous reset mid-HOLD, away from any clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("arst_grant", 64'(grant), 64'h0);
    check("arst_value", 64'(value), 64'h0);
    check("arst_busy",  64'(busy),  64'h0);
    check("arst_owner", 64'(owner), 64'h0);
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_grant", 64'(grant), 64'h4);
    check("post_rst_value", 64'(value), 64'hAAAA_0001);

`ifdef SSD_ARB_PRIORITY_EN
    // Override: req0 rising at dwell count 3 of owner 2 takes the display next edge.
    req = 4'b0000;
    step();
    req = 4'b0100;
    step();
    check("pri_o2_grant", 64'(grant), 64'h4);
    repeat (3) step();
    req = 4'b0101;
    step();
    check("pri_override_grant", 64'(grant), 64'h1);
    check("pri_override_value", 64'(value), 64'hA0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ssd_display_arbiter.md
Name: ssd_display_arbiter

Overview:
- Shares the 8-digit seven-segment display between up to NUM_REQ requesters. Each requester presents a 32-bit packed-hex value.
- Round-robin arbitration with a minimum dwell time, so a granted value stays visible long enough to read.
- Output value feeds the display manager's 32-bit input directly; one grant is active at a time.

Parameters:
- NUM_REQ, 4: number of requesters; legal range 2..4.
- DWELL_CYCLES, 100_000_000: minimum ownership time in clocks (1 s at 100 MHz); must be >= 2.
- DATA_W, 32: width of each requester value (8 hex digits).

Ports:
- ssd_arbiter_clk  in  1  system clock.
- ssd_arbiter_rst_n  in  1  reset, asynchronous, active-low.
- ssd_arbiter_req  in  NUM_REQ  level request per requester; bit i = requester i.
- ssd_arbiter_data  in  NUM_REQ*DATA_W  flattened values; requester i occupies [i*DATA_W +: DATA_W].
- ssd_arbiter_grant  out  NUM_REQ  one-hot grant; all zeros when idle.
- ssd_arbiter_owner  out  2  index of current or last owner.
- ssd_arbiter_value  out  DATA_W  registered value to the display manager.
- ssd_arbiter_busy  out  1  high while any grant is active.

Behaviour:
- Reset values (asynchronous): grant=0, owner=0, value=0, busy=0, dwell counter=0, round-robin pointer=0, state=IDLE.
- States:
  - IDLE: no grant.
  - HOLD: grant active, dwell counter running, no preemption.
  - OPEN: dwell expired, owner keeps the display until another requester asks.
- IDLE -> HOLD: on the first edge where req != 0. Winner is the first set bit searching upward (with wrap) from the pointer. Grant and busy assert on that edge; counter loads 0.
- HOLD:
  - Counter increments each clock.
  - At count == DWELL_CYCLES-1, go to OPEN; counter stops.
- OPEN:
  - If any other requester is high, switch directly to the next round-robin winner: new grant on the next edge, state HOLD, counter=0.
  - Otherwise stay in OPEN holding the current owner.
- Owner drops req in HOLD or OPEN (release):
  - If other requests are pending, switch to the next winner on the next edge (HOLD, counter=0).
  - Otherwise go to IDLE: grant=0, busy=0, value holds its last contents.
- Pointer rule: on every new grant the pointer becomes owner+1 mod NUM_REQ, so the previous owner has lowest priority next round.
- Value path:
  - value <= data of the granted requester every clock while busy, so live updates from the owner track with 1-cycle latency.
  - A new grant's data appears on value in the same edge the grant asserts; the mux selects on the next-state winner.
  - While IDLE, value holds.
- Simultaneous owner release and dwell expiry: the release rule takes precedence.
- Requests from non-owners during HOLD are ignored until expiry or release; nothing is latched or queued.
- Invariants: grant is always zero or one-hot. busy == |grant.
- Reset asserted mid-operation: immediate return to reset values; no grant persists.

Optional Feature:
- Macro: SSD_ARB_PRIORITY_EN.
- Defined:
  - requester 0 is an override source. If req[0] rises while another requester owns the display (HOLD or OPEN), requester 0 is granted on the next edge (HOLD, counter=0) regardless of dwell.
  - While requester 0 owns the display, others cannot take it until it releases or its dwell expires and they request.
  - The pointer is not updated by override grants.
- Undefined: requester 0 is an ordinary round-robin participant.

Decomposition:
- Shared header/package ssd_arb_pkg:
  - state encodings (IDLE=2'd0, HOLD=2'd1, OPEN=2'd2)
  - default DWELL_CYCLES
  - DATA_W
  - owner-index width
- Sub-module ssd_rr_picker: combinational. Inputs are request vector, mask (excludes current owner), and pointer; outputs one-hot winner, index and any_valid. Instantiated once.

Test Plan:
- Use DWELL_CYCLES=10 for all scenarios.
- Reset then req=4'b0100, data2=32'h1234_5678 -> next edge: grant=4'b0100, owner=2, value=32'h12345678, busy=1.
- req0 and req2 held high, req0 first granted -> grant stays 0001 for exactly 10 clocks; switches to 0100 on the 11th edge, then back to 0001 after a further 10.
- Owner 1 alone, dwell expired, no other requests -> grant held indefinitely in OPEN. Owner drops req -> next edge grant=0, busy=0, value unchanged.
- Owner 3 drops req at cycle 4 of dwell while req1 high -> grant=4'b0010 next edge, counter restarts at 0.
- Owner 2 changes data 32'hAAAA_0000 -> 32'hAAAA_0001 mid-dwell -> value follows 1 cycle later.
- rst_n pulsed low mid-HOLD -> grant=0, value=0, busy=0 asynchronously.
- With SSD_ARB_PRIORITY_EN defined: owner 2 at dwell cycle 3, req0 rises -> grant=4'b0001 on the next edge.
